// File: rtl/noc_pkg.sv
// Shared NoC definitions for the ifmap multicast bus: default tag widths and
// the receiver pass-state encoding.
package noc_pkg;

  localparam int NOC_ROW_TAG_WIDTH = 4;
  localparam int NOC_COL_TAG_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO with a combinational head; holds matched ifmap words
// until the PE takes them.
module noc_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  push_ok;
  logic                  pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage is not reset; the head is forced to zero whenever nothing is held.
  assign head = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ifmap_mc_receiver.sv
// Ifmap multicast receiver: filters bus packets on (row_tag, col_tag), buffers the
// matches for one PE and signals done once the expected number has been delivered.
module ifmap_mc_receiver
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = NOC_ROW_TAG_WIDTH,
  parameter int COL_TAG_WIDTH = NOC_COL_TAG_WIDTH,
  parameter int FIFO_DEPTH    = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     config_en,
  input  logic [ROW_TAG_WIDTH-1:0] config_row_id,
  input  logic [COL_TAG_WIDTH-1:0] config_col_id,
  input  logic                     config_active,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     expected_count,
  input  logic                     bus_valid,
  output logic                     bus_ready,
  input  logic [DATA_WIDTH-1:0]    bus_data,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     pe_valid,
  input  logic                     pe_ready,
  output logic [DATA_WIDTH-1:0]    pe_data,
  output logic                     busy,
  output logic                     done
);

  rx_state_t                state_reg;
  logic [ROW_TAG_WIDTH-1:0] row_id_reg;
  logic [COL_TAG_WIDTH-1:0] col_id_reg;
  logic                     active_reg;
  logic [CNT_WIDTH-1:0]     expected_reg;
  logic [CNT_WIDTH-1:0]     count_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic fifo_full;
  logic fifo_empty;
  logic match;
  logic push;
  logic pop;
  logic last_push;

  // Gating with bus_valid keeps bus_ready independent of the tags on idle bus cycles.
  assign match = bus_valid & active_reg &
                 (row_tag == row_id_reg) & (col_tag == col_id_reg);

  // No pass-through: a full buffer blocks a matching packet even if the PE pops now.
  assign bus_ready = (state_reg == RECV) & (~match | ~fifo_full);
  assign push      = bus_valid & bus_ready & match;
  assign pe_valid  = ~fifo_empty;
  assign pop       = pe_valid & pe_ready;
  assign last_push = push & ((count_reg + CNT_WIDTH'(1)) == expected_reg);

  assign busy = busy_reg;
  assign done = done_reg;

  noc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (bus_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (pe_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      row_id_reg   <= '0;
      col_id_reg   <= '0;
      active_reg   <= 1'b0;
      expected_reg <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (config_en) begin
            row_id_reg <= config_row_id;
            col_id_reg <= config_col_id;
            active_reg <= config_active;
          end
          if (start) begin
            expected_reg <= expected_count;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= (expected_count == '0) ? DRAIN : RECV;
          end
        end
        RECV: begin
          if (push) count_reg <= count_reg + CNT_WIDTH'(1);
          if (last_push) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_mc_receiver.sv
// Scoreboard bench for ifmap_mc_receiver: directed scenarios plus randomized passes,
// checked against a pass-level reference model of the receive rules.
module tb_ifmap_mc_receiver;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int CW = 5;
  localparam int DEPTH = 2;
  localparam int NW = 8;

  logic          clk;
  logic          reset_n;
  logic          config_en;
  logic [RW-1:0] config_row_id;
  logic [CW-1:0] config_col_id;
  logic          config_active;
  logic          start;
  logic [NW-1:0] expected_count;
  logic          bus_valid;
  logic          bus_ready;
  logic [DW-1:0] bus_data;
  logic [RW-1:0] row_tag;
  logic [CW-1:0] col_tag;
  logic          pe_valid;
  logic          pe_ready;
  logic [DW-1:0] pe_data;
  logic          busy;
  logic          done;

  ifmap_mc_receiver #(
    .DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
    .FIFO_DEPTH(DEPTH), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .config_en(config_en), .config_row_id(config_row_id),
    .config_col_id(config_col_id), .config_active(config_active),
    .start(start), .expected_count(expected_count),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data),
    .row_tag(row_tag), .col_tag(col_tag),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] sb_q[$];
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_active;
  logic          m_in_pass;
  int            m_remaining;
  int            occ_now;
  logic          exp_done;
  logic          done_seen;
  int            done_count;
  logic          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_row = '0; m_col = '0; m_active = 1'b0;
    m_in_pass = 1'b0; m_remaining = 0; occ_now = 0;
    exp_done = 1'b0; done_seen = 1'b0;
  endtask

  // Monitor: checks the PE side and pass status shortly after each falling edge.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      occ_now = sb_q.size();
      check("pe_valid", pe_valid, occ_now != 0);
      check("busy", busy, m_in_pass);
      check("done", done, exp_done);
      if (done) begin
        done_count++;
        done_seen = 1'b1;
      end
      if (pe_valid && pe_ready) begin
        if (sb_q.size() == 0) begin
          check("pe_unexpected_pop", 32'(pe_valid), 32'd0);
        end else begin
          $display("pe  pop  data=%h expected=%h", pe_data, sb_q[0]);
          check("pe_data", pe_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
      end
      // done follows the first drain cycle that finds the buffer empty
      exp_done = m_in_pass && (m_remaining == 0) && !exp_done && (occ_now == 0);
    end
  end

  // One bus cycle: inputs are already driven for this cycle.
  task automatic tick();
    logic mm;
    logic exp_br;
    #3;
    mm = bus_valid && m_active && (row_tag == m_row) && (col_tag == m_col);
    exp_br = m_in_pass && (m_remaining != 0) && (!mm || occ_now < DEPTH);
    check("bus_ready", bus_ready, exp_br);
    last_acc = bus_valid && bus_ready;
    if (last_acc) begin
      $display("bus %s tag=(%0d,%0d) data=%h", mm ? "take" : "drop", row_tag, col_tag, bus_data);
      if (mm && m_remaining != 0) begin
        sb_q.push_back(bus_data);
        m_remaining--;
      end
    end
    if (!m_in_pass) begin
      if (config_en) begin
        m_row = config_row_id; m_col = config_col_id; m_active = config_active;
      end
      if (start) begin
        m_in_pass = 1'b1;
        m_remaining = int'(expected_count);
      end
    end
    if (done_seen) begin
      m_in_pass = 1'b0;
      done_seen = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_config(input int r, input int c, input logic a);
    config_en = 1'b1;
    config_row_id = RW'(r); config_col_id = CW'(c); config_active = a;
    tick();
    config_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    expected_count = NW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int r, input int c, input int d);
    bus_valid = 1'b1;
    row_tag = RW'(r); col_tag = CW'(c); bus_data = DW'(d);
    last_acc = 1'b0;
    for (int i = 0; i < 40 && !last_acc; i++) tick();
    check("bus_accept_timeout", last_acc, 1'b1);
    bus_valid = 1'b0;
  endtask

  task automatic wait_end(input int max_cycles);
    for (int i = 0; i < max_cycles && m_in_pass; i++) tick();
    check("pass_end_timeout", m_in_pass, 1'b0);
    tick();
  endtask

  task automatic mid_reset();
    #4;
    reset_n = 1'b0;
    #1;
    check("rst_pe_valid", pe_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bus_ready", bus_ready, 1'b0);
    check("rst_pe_data", pe_data, '0);
    check("rst_done", done, 1'b0);
    model_reset();
    bus_valid = 1'b0; start = 1'b0; config_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int d0;

  initial begin
    reset_n = 1'b0;
    config_en = 1'b0; config_row_id = '0; config_col_id = '0; config_active = 1'b0;
    start = 1'b0; expected_count = '0;
    bus_valid = 1'b0; bus_data = '0; row_tag = '0; col_tag = '0;
    pe_ready = 1'b0;
    done_count = 0; last_acc = 1'b0;
    model_reset();
    #1;
    check("reset_bus_ready", bus_ready, 1'b0);
    check("reset_pe_valid", pe_valid, 1'b0);
    check("reset_pe_data", pe_data, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: basic filtering
    d0 = done_count;
    do_config(2, 3, 1'b1);
    do_start(3);
    pe_ready = 1'b1;
    send(2, 3, 'hA); send(1, 3, 'hB); send(2, 3, 'hC); send(2, 4, 'hD); send(2, 3, 'hE);
    wait_end(50);
    check("t1_done_count", done_count - d0, 1);

    // 2: backpressure
    d0 = done_count;
    pe_ready = 1'b0;
    do_start(4);
    send(2, 3, 1); send(2, 3, 2);
    bus_valid = 1'b1; row_tag = 2; col_tag = 3; bus_data = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_blocked", last_acc, 1'b0);
    end
    send(2, 4, 'h55);
    pe_ready = 1'b1;
    send(2, 3, 3); send(2, 3, 4);
    wait_end(50);
    check("t2_done_count", done_count - d0, 1);

    // 3: PE gated off
    d0 = done_count;
    do_config(2, 3, 1'b0);
    do_start(1);
    for (int i = 0; i < 4; i++) send(2, 3, 'h100 + i);
    for (int i = 0; i < 5; i++) tick();
    check("t3_no_done", done_count - d0, 0);
    check("t3_busy", busy, 1'b1);
    mid_reset();

    // 4: empty pass
    d0 = done_count;
    bus_valid = 1'b1; row_tag = 0; col_tag = 0;
    do_start(0);
    check("t4_busy_c1", busy, 1'b1);
    tick();
    check("t4_busy_c2", busy, 1'b1);
    tick();
    check("t4_busy_off", busy, 1'b0);
    bus_valid = 1'b0;
    check("t4_done_count", done_count - d0, 1);

    // 5: reset with two buffered words, then a fresh pass
    do_config(2, 3, 1'b1);
    pe_ready = 1'b0;
    do_start(4);
    send(2, 3, 'h21); send(2, 3, 'h22);
    tick();
    mid_reset();
    d0 = done_count;
    pe_ready = 1'b1;
    do_config(2, 3, 1'b1);
    do_start(2);
    send(2, 3, 'h31); send(2, 3, 'h32);
    wait_end(50);
    check("t5_done_count", done_count - d0, 1);

    // 6: config during RECV is ignored
    d0 = done_count;
    do_start(2);
    send(2, 3, 'h41);
    do_config(5, 5, 1'b1);
    send(5, 5, 'h42);
    send(2, 3, 'h43);
    wait_end(50);
    do_config(5, 5, 1'b1);
    do_start(1);
    send(2, 3, 'h44);
    send(5, 5, 'h45);
    wait_end(50);
    check("t6_done_count", done_count - d0, 2);

    // 7: randomized passes
    for (int p = 0; p < 20; p++) begin
      int r, c, n;
      r = $urandom_range(0, 15); c = $urandom_range(0, 31); n = $urandom_range(1, 6);
      d0 = done_count;
      do_config(r, c, 1'b1);
      do_start(n);
      for (int i = 0; i < 2000 && m_in_pass; i++) begin
        bus_valid = ($urandom_range(0, 3) != 0);
        bus_data = DW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          row_tag = RW'(r); col_tag = CW'(c);
        end else begin
          row_tag = RW'($urandom); col_tag = CW'($urandom);
        end
        pe_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
      bus_valid = 1'b0;
      pe_ready = 1'b1;
      check("rand_pass_end", m_in_pass, 1'b0);
      tick();
      check("rand_done_count", done_count - d0, 1);
      if (m_in_pass) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
